// File: rtl/multiply_top.sv
// ============================================================================
//  Module   : multiply_top
//  Purpose  : Signed fixed-point (Q_BITS fractional bits) multiplier between a
//             pair of first-word-fall-through input FIFOs and an output FIFO.
//             Operands are converted to sign + magnitude and multiplied with a
//             radix-2 shift-add loop of D_WIDTH cycles. The product is then
//             shifted right by Q_BITS (truncating toward zero) and re-signed.
//  Ports    : clock        - rising-edge clock
//             reset        - synchronous, active-high reset
//             multiplicand - operand A from input FIFO dout
//             multiplier   - operand B from input FIFO dout
//             in_empty     - either input FIFO empty
//             in_rd_en     - pops both input FIFOs (one cycle)
//             out_full     - output FIFO full
//             out_wr_en    - pushes out_din into the output FIFO (one cycle)
//             out_din      - signed fixed-point product
//  Config   : `define MULTIPLY_SATURATE_EN to clamp out-of-range results to
//             the most positive / most negative value; otherwise the result
//             wraps to its low D_WIDTH bits.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiply_top #(
    parameter int Q_BITS  = 10,
    parameter int D_WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [D_WIDTH-1:0] multiplicand,
    input  logic [D_WIDTH-1:0] multiplier,
    input  logic               in_empty,
    output logic               in_rd_en,
    input  logic               out_full,
    output logic               out_wr_en,
    output logic [D_WIDTH-1:0] out_din
);

    localparam int                 c_cnt_w    = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(D_WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [D_WIDTH-1:0] c_one      = D_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_cnt_w-1:0]     r_count;
    logic [2*D_WIDTH-1:0]   r_acc;
    logic [D_WIDTH-1:0]     r_a;
    logic [D_WIDTH-1:0]     r_b;
    logic                   r_sign;
    logic [D_WIDTH-1:0]     r_dout;

    logic [D_WIDTH-1:0]     w_mag_a;
    logic [D_WIDTH-1:0]     w_mag_b;
    logic [2*D_WIDTH-1:0]   w_partial;
    logic [2*D_WIDTH-1:0]   w_acc_next;
    logic [D_WIDTH-1:0]     w_mag_lo;
    logic [D_WIDTH-1:0]     w_wrap;
    logic [D_WIDTH-1:0]     w_result;

    // Two's complement magnitude; the most negative value maps onto
    // 2^(D_WIDTH-1), which is representable as an unsigned D_WIDTH-bit value.
    assign w_mag_a = multiplicand[D_WIDTH-1] ? (~multiplicand + c_one) : multiplicand;
    assign w_mag_b = multiplier[D_WIDTH-1]   ? (~multiplier + c_one)   : multiplier;

    // One shift-add step: add A << count when bit 'count' of B is set.
    assign w_partial  = r_b[r_count] ? ({{D_WIDTH{1'b0}}, r_a} << r_count) : '0;
    assign w_acc_next = r_acc + w_partial;

    // Dropping the low Q_BITS of the unsigned magnitude truncates toward zero.
    // Negating a zero magnitude yields zero, so no negative zero can appear.
    assign w_mag_lo = w_acc_next[Q_BITS +: D_WIDTH];
    assign w_wrap   = r_sign ? (~w_mag_lo + c_one) : w_mag_lo;

`ifdef MULTIPLY_SATURATE_EN
    localparam logic [2*D_WIDTH-1:0] c_pos_lim = {{(D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
    localparam logic [2*D_WIDTH-1:0] c_neg_lim = {{D_WIDTH{1'b0}}, 1'b1, {(D_WIDTH-1){1'b0}}};

    logic [2*D_WIDTH-1:0] w_mag;
    assign w_mag = w_acc_next >> Q_BITS;

    always_comb begin
        w_result = w_wrap;
        if (!r_sign && (w_mag > c_pos_lim)) begin
            w_result = {1'b0, {(D_WIDTH-1){1'b1}}};
        end else if (r_sign && (w_mag > c_neg_lim)) begin
            w_result = {1'b1, {(D_WIDTH-1){1'b0}}};
        end
    end
`else
    assign w_result = w_wrap;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and FIFO handshakes. Both strobes are gated by reset so
    // an aborted operation can neither pop nor push.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_rd_en     = 1'b0;
        out_wr_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!in_empty && !reset) begin
                    in_rd_en     = 1'b1;
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (r_count == c_last_cnt) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!out_full && !reset) begin
                    out_wr_en    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
            r_acc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sign  <= 1'b0;
            r_dout  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_rd_en) begin
                        r_a     <= w_mag_a;
                        r_b     <= w_mag_b;
                        r_sign  <= multiplicand[D_WIDTH-1] ^ multiplier[D_WIDTH-1];
                        r_acc   <= '0;
                        r_count <= '0;
                    end
                end
                S_CALC: begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + c_cnt_one;
                    // Capture the result from the final accumulator value so it
                    // is already stable on the first WRITE cycle.
                    if (r_count == c_last_cnt) begin
                        r_dout <= w_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_din = r_dout;

endmodule

`default_nettype wire

// File: tb/tb_multiply_top.sv
// ============================================================================
//  Module   : tb_multiply_top
//  Purpose  : Self-checking bench for multiply_top. An input FIFO model feeds
//             operand pairs; a signed-arithmetic reference model predicts each
//             product, and a negedge monitor scores every output write.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multiply_top;

    localparam int c_q = 10;
    localparam int c_w = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   multiplicand;
    logic [31:0]   multiplier;
    logic          in_empty;
    logic          in_rd_en;
    logic          out_full;
    logic          out_wr_en;
    logic [31:0]   out_din;

    int            errors = 0;
    int            checks = 0;
    int            n_wr   = 0;
    longint        cyc    = 0;

    // Input FIFO model (first-word-fall-through)
    logic [31:0]   fa [0:255];
    logic [31:0]   fb [0:255];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic [31:0]   exp_q [$];

    assign in_empty     = (wr_ptr == rd_ptr);
    assign multiplicand = fa[rd_ptr % 256];
    assign multiplier   = fb[rd_ptr % 256];

    multiply_top #(.Q_BITS(c_q), .D_WIDTH(c_w)) dut (
        .clock        (clock),
        .reset        (reset),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .in_empty     (in_empty),
        .in_rd_en     (in_rd_en),
        .out_full     (out_full),
        .out_wr_en    (out_wr_en),
        .out_din      (out_din)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (in_rd_en) rd_ptr <= rd_ptr + 1;
    end

    // Reference: full signed product, divided by 2^Q (SV division truncates
    // toward zero), then clamped or wrapped to 32 bits.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        longint p;
        longint q;
        p = longint'($signed(a)) * longint'($signed(b));
        q = p / (longint'(1) << c_q);
`ifdef MULTIPLY_SATURATE_EN
        if (q > 64'sd2147483647)  return 32'h7FFFFFFF;
        if (q < -64'sd2147483648) return 32'h80000000;
`endif
        return q[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: score every write and the pop-while-empty rule.
    always @(negedge clock) begin
        if (in_rd_en) begin
            checks++;
            if (in_empty !== 1'b0) begin
                errors++;
                $display("FAIL rd_while_empty: in_rd_en=1 in_empty=%b required 0", in_empty);
            end
        end
        if (out_wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: out_din=%h with no pending result", out_din);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (out_din !== e) begin
                    errors++;
                    $display("FAIL scoreboard: out_din=%h expected %h", out_din, e);
                end
            end
            n_wr++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input bit expect_it);
        fa[wr_ptr % 256] = a;
        fb[wr_ptr % 256] = b;
        if (expect_it) exp_q.push_back(model(a, b));
        wr_ptr++;
    endtask

    task automatic wait_rd(output longint c, output bit ok);
        ok = 1'b0;
        c  = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (in_rd_en === 1'b1) begin
                c  = cyc;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("rd_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_wr(output longint c, output bit ok);
        ok = 1'b0;
        c  = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (out_wr_en === 1'b1) begin
                c  = cyc;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wr_timeout", 32'd0, 32'd1);
    endtask

    // Wait for the next pop and its write; pin latency and the literal result.
    task automatic expect_pair(input string name, input logic [31:0] exp_lit);
        longint rc;
        longint wc;
        bit     ok;
        wait_rd(rc, ok);
        if (ok) begin
            wait_wr(wc, ok);
            if (ok) begin
                check({name, "_latency"}, 32'(wc - rc), 32'd33);
                check(name, out_din, exp_lit);
            end
        end
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint rc;
        bit     ok;
        int     base;
        logic [31:0] a;
        logic [31:0] b;

        for (int i = 0; i < 256; i++) begin
            fa[i] = '0;
            fb[i] = '0;
        end
        reset    = 1'b1;
        out_full = 1'b0;

        // Model pinned to hand-computed values
        check("model_2x3",     model(32'h00000800, 32'h00000C00), 32'h00001800);
        check("model_m15x2",   model(32'hFFFFFA00, 32'h00000800), 32'hFFFFF400);
        check("model_trunc",   model(32'hFFFFFFFF, 32'h00000001), 32'h00000000);

        // Reset state, with data waiting so in_rd_en gating is exercised
        tick();
        push(32'h00000800, 32'h00000C00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("reset_rd_en",  {31'd0, in_rd_en},  32'd0);
            check("reset_wr_en",  {31'd0, out_wr_en}, 32'd0);
            check("reset_out_din", out_din,           32'd0);
        end
        tick();
        reset = 1'b0;

        // 2.0 * 3.0
        expect_pair("two_times_three", 32'h00001800);

        // -1.5 * 2.0
        push(32'hFFFFFA00, 32'h00000800, 1'b1);
        expect_pair("neg_1p5_times_2", 32'hFFFFF400);

        // Tiny negative product truncates to zero, not negative zero
        push(32'hFFFFFFFF, 32'h00000001, 1'b1);
        expect_pair("trunc_to_zero", 32'h00000000);

        // Range handling
        push(32'h40000000, 32'h00000800, 1'b1);
`ifdef MULTIPLY_SATURATE_EN
        expect_pair("pos_overflow", 32'h7FFFFFFF);
`else
        expect_pair("pos_overflow", 32'h80000000);
`endif
        push(32'h80000000, 32'h00000800, 1'b1);
`ifdef MULTIPLY_SATURATE_EN
        expect_pair("neg_overflow", 32'h80000000);
`else
        expect_pair("neg_overflow", 32'h00000000);
`endif

        // Backpressure: 3.0 * -4.0 held for 5 WRITE cycles
        out_full = 1'b1;
        push(32'h00000C00, 32'hFFFFF000, 1'b1);
        wait_rd(rc, ok);
        if (ok) begin
            repeat (32) @(negedge clock);
            for (int k = 0; k < 5; k++) begin
                @(negedge clock);
                check("bp_wr_low",   {31'd0, out_wr_en}, 32'd0);
                check("bp_din_hold", out_din,            32'hFFFFD000);
            end
            tick();
            out_full = 1'b0;
            @(negedge clock);
            check("bp_release_wr", {31'd0, out_wr_en}, 32'd1);
            check("bp_release_din", out_din,           32'hFFFFD000);
            @(negedge clock);
            check("bp_single_wr",  {31'd0, out_wr_en}, 32'd0);
        end
        tick();

        // Reset at CALC count 10 aborts the pair
        push(32'h00001400, 32'h00000C00, 1'b0);
        wait_rd(rc, ok);
        if (ok) begin
            base = n_wr;
            repeat (11) tick();
            reset = 1'b1;
            tick();
            reset = 1'b0;
            @(negedge clock);
            check("abort_out_din_cleared", out_din, 32'd0);
            repeat (45) @(negedge clock);
            check("abort_no_write", 32'(n_wr - base), 32'd0);
        end
        tick();
        push(32'h00000400, 32'h00000400, 1'b1);
        expect_pair("one_times_one", 32'h00000400);

        // Random pairs with random backpressure
        base = n_wr;
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 2 == 1) begin
                a = 32'($signed(32'($urandom_range(0, 200000))) - 100000);
                b = 32'($signed(32'($urandom_range(0, 200000))) - 100000);
            end
            if (i == 3) a = 32'h80000000;
            push(a, b, 1'b1);
        end
        for (int i = 0; i < 3000; i++) begin
            if (n_wr - base >= 16) break;
            @(posedge clock);
            #1;
            out_full = ($urandom_range(0, 2) == 0);
        end
        out_full = 1'b0;
        check("random_count", 32'(n_wr - base), 32'd16);
        check("random_drained", 32'(exp_q.size()), 32'd0);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
